// File: rtl/wave_capture_ctrl.sv
// Capture-and-swap controller for the double-buffered waveform display RAM.
// Arms on a rising zero crossing (or a timeout), fills the hidden half, then swaps halves when the display is idle.
module wave_capture_ctrl #(
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_sample_ready,
  input  logic signed [15:0] new_sample_in,
  input  logic               wave_display_idle,
  output logic [8:0]         write_address,
  output logic               write_enable,
  output logic [7:0]         write_sample,
  output logic               read_index,
  output logic               capturing
);

  localparam logic [1:0] S_ARMED  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam int             TW       = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT);
  localparam logic [3:0]     DEC_LAST = 4'(DECIM - 1);

  // Offset-binary conversion of the sample's top byte; 0x80 is the zero level.
  function automatic logic [7:0] to_offset_bin(input logic signed [15:0] s);
    return s[15:8] ^ 8'h80;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          prev_q, prev_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    dec_q, dec_d, dec_inc;
  logic          ri_q, ri_d;
  logic          we_q, we_d;
  logic [8:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          cap_q, cap_d;
  logic          crossing, forced;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    dec_d    = dec_q;
    ri_d     = ri_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    tmo_inc  = tmo_q + 1'b1;
    dec_inc  = (dec_q == DEC_LAST) ? 4'd0 : dec_q + 4'd1;
    crossing = prev_q && !new_sample_in[15];
    forced   = (TIMEOUT != 0) && (tmo_inc == TMO_LAST);

    case (state_q)
      S_ARMED: begin
        if (new_sample_ready) begin
          prev_d = new_sample_in[15];
          tmo_d  = tmo_inc;
          if (crossing || forced) begin
            we_d    = 1'b1;
            addr_d  = {~ri_q, 8'd0};
            data_d  = to_offset_bin(new_sample_in);
            idx_d   = 8'd1;
            dec_d   = 4'd0;
            tmo_d   = '0;
            state_d = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready) begin
          dec_d = dec_inc;
          if (dec_inc == 4'd0) begin
            we_d   = 1'b1;
            addr_d = {~ri_q, idx_q};
            data_d = to_offset_bin(new_sample_in);
            idx_d  = idx_q + 8'd1;
            if (idx_q == 8'd255) state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Samples arriving here are dropped; the swap only waits for the display to leave the waveform.
        if (wave_display_idle) begin
          ri_d    = ~ri_q;
          prev_d  = 1'b0;
          tmo_d   = '0;
          state_d = S_ARMED;
        end
      end
      default: state_d = S_ARMED;
    endcase

    cap_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ARMED;
      prev_q  <= 1'b0;
      tmo_q   <= '0;
      idx_q   <= 8'd0;
      dec_q   <= 4'd0;
      ri_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 9'd0;
      data_q  <= 8'd0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      ri_q    <= ri_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
    end
  end

  assign write_address = addr_q;
  assign write_enable  = we_q;
  assign write_sample  = data_q;
  assign read_index    = ri_q;
  assign capturing     = cap_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: expected RAM writes are queued as stimulus is driven and popped as writes appear.
module tb_wave_capture_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ready = 1'b0;
  logic signed [15:0] sample = '0;
  logic               idle = 1'b0;

  logic [8:0] addr0, addr1, addr2;
  logic       we0, we1, we2;
  logic [7:0] data0, data1, data2;
  logic       ri0, ri1, ri2;
  logic       cap0, cap1, cap2;

  always #5 clk = ~clk;

  wave_capture_ctrl #(.DECIM(1), .TIMEOUT(4096)) u0 (
    .clk(clk), .reset(reset), .new_sample_ready(ready), .new_sample_in(sample),
    .wave_display_idle(idle), .write_address(addr0), .write_enable(we0),
    .write_sample(data0), .read_index(ri0), .capturing(cap0));

  wave_capture_ctrl #(.DECIM(4), .TIMEOUT(16)) u1 (
    .clk(clk), .reset(reset), .new_sample_ready(ready), .new_sample_in(sample),
    .wave_display_idle(idle), .write_address(addr1), .write_enable(we1),
    .write_sample(data1), .read_index(ri1), .capturing(cap1));

  wave_capture_ctrl #(.DECIM(1), .TIMEOUT(0)) u2 (
    .clk(clk), .reset(reset), .new_sample_ready(ready), .new_sample_in(sample),
    .wave_display_idle(idle), .write_address(addr2), .write_enable(we2),
    .write_sample(data2), .read_index(ri2), .capturing(cap2));

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
    logic       last;
  } wr_t;

  wr_t  exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   sel = 0;
  logic [7:0] last_data = '0;

  logic [8:0] addr_m;
  logic       we_m, cap_m, ri_m;
  logic [7:0] data_m;

  always_comb begin
    addr_m = addr0; we_m = we0; data_m = data0; cap_m = cap0; ri_m = ri0;
    if (sel == 1) begin
      addr_m = addr1; we_m = we1; data_m = data1; cap_m = cap1; ri_m = ri1;
    end else if (sel == 2) begin
      addr_m = addr2; we_m = we2; data_m = data2; cap_m = cap2; ri_m = ri2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [15:0] s);
    return s[15:8] ^ 8'h80;
  endfunction

  // Triangle of period 500 samples between -1000 and +1000 in steps of 8; k=125 is the rising zero.
  function automatic logic [15:0] tri_wave(input int k);
    int p;
    p = k % 500;
    if (p <= 250) return 16'(-1000 + 8 * p);
    return 16'(1000 - 8 * (p - 250));
  endfunction

  task automatic push_w(input int a, input logic [15:0] s, input bit last);
    wr_t e;
    e.a = 9'(a);
    e.d = conv(s);
    e.last = last;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (we_m === 1'b1) begin
      wr_t e;
      wr_cnt++;
      last_data = data_m;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(addr_m), 32'(e.a));
        chk("wr_data", 32'(data_m), 32'(e.d));
        chk("wr_capturing", 32'(cap_m), 32'(!e.last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic stream_tri(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      ready = 1'b1;
      sample = tri_wave(k);
      step();
    end
    ready = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] s);
    ready = 1'b1;
    sample = s;
    step();
    ready = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_data", 32'(data0), 32'd0);
    chk("rst_ri", 32'(ri0), 32'd0);
    chk("rst_cap", 32'(cap0), 32'd0);
    chk("rst_ri_u1", 32'(ri1), 32'd0);

    // Capture 1: triangle, DECIM=1, hidden half is 256..511
    sel = 0; wr_cnt = 0;
    for (int k = 125; k <= 380; k++) push_w(256 + k - 125, tri_wave(k), k == 380);
    stream_tri(0, 380);
    repeat (3) step();
    chk("cap1_q_empty", 32'(exp_q.size()), 32'd0);
    chk("cap1_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("cap1_cap_low", 32'(cap0), 32'd0);

    // Idle held low for 1000 cycles with live samples: nothing written, no swap
    stream_tri(381, 1380);
    chk("wait_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("wait_ri", 32'(ri0), 32'd0);
    idle = 1'b1;
    @(negedge clk);
    chk("swap1_before", 32'(ri0), 32'd0);
    step();
    idle = 1'b0;
    chk("swap1_after", 32'(ri0), 32'd1);

    // Capture 2: hidden half is now 0..255
    wr_cnt = 0;
    for (int k = 125; k <= 380; k++) push_w(k - 125, tri_wave(k), k == 380);
    stream_tri(0, 380);
    repeat (3) step();
    chk("cap2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("cap2_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("cap2_ri_hold", 32'(ri0), 32'd1);
    idle = 1'b1;
    step();
    idle = 1'b0;
    chk("swap2_after", 32'(ri0), 32'd0);

    // Reset after 100 writes abandons the capture; the next one restarts at 256
    wr_cnt = 0;
    for (int k = 125; k <= 224; k++) push_w(256 + k - 125, tri_wave(k), 1'b0);
    stream_tri(0, 224);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_we", 32'(we0), 32'd0);
    chk("midrst_addr", 32'(addr0), 32'd0);
    chk("midrst_data", 32'(data0), 32'd0);
    chk("midrst_ri", 32'(ri0), 32'd0);
    chk("midrst_cap", 32'(cap0), 32'd0);
    chk("midrst_wr_cnt", 32'(wr_cnt), 32'd100);
    for (int k = 625; k <= 880; k++) push_w(256 + k - 625, tri_wave(k), k == 880);
    stream_tri(225, 880);
    repeat (3) step();
    chk("recap_q_empty", 32'(exp_q.size()), 32'd0);
    chk("recap_wr_cnt", 32'(wr_cnt), 32'd356);

    // DECIM=4: sample j carries j in its top byte, so each stored index is visible in the data
    do_reset();
    sel = 1; wr_cnt = 0;
    for (int m = 0; m <= 255; m++) push_w(256 + m, 16'(4 * m * 256), m == 255);
    for (int j = -1; j <= 1020; j++) begin
      ready = 1'b1;
      sample = 16'(j * 256);
      step();
    end
    ready = 1'b0;
    repeat (3) step();
    chk("dec_q_empty", 32'(exp_q.size()), 32'd0);
    chk("dec_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("dec_addr255_data", 32'(last_data), 32'h7C);

    // Constant +500 with TIMEOUT=16: forced trigger on the 16th sample only
    do_reset();
    wr_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) push_w(256, 16'sd500, 1'b0);
      send_one(16'sd500);
    end
    chk("tmo_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("tmo_q_empty", 32'(exp_q.size()), 32'd0);
    chk("tmo_capturing", 32'(cap1), 32'd1);

    // Constant +500 with TIMEOUT=0: never triggers
    do_reset();
    sel = 2; wr_cnt = 0;
    for (int i = 0; i < 40; i++) send_one(16'sd500);
    chk("notmo_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("notmo_cap", 32'(cap2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
